enc8x3_serializer: RTL
======================

Name: enc8x3_serializer

Overview:
- Sequential 8-to-3 encoder. It is the encode-side counterpart of the team's 3-to-8 decoder.
- Accepts an N_IN-bit request vector over a valid/ready handshake and latches it.
- Emits the index of every set bit, one per output beat, in priority order, clearing each bit as it is consumed.
- Used wherever a one-hot or multi-hot vector must be turned back into binary indices for the decoder or for downstream logic.

Parameters:
- N_IN, default 8: input vector width; must be a power of 2 and at least 2.
- LSB_FIRST, default 0: 0 means the highest set bit is emitted first; 1 means the lowest set bit is emitted first.
- Derived localparam IDX_W = $clog2(N_IN), which is 3 at the default.

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset
- in_vec  input  N_IN  request vector
- in_valid  input  1  in_vec valid
- in_ready  output  1  block can accept a vector
- out_idx  output  IDX_W  encoded bit index
- out_valid  output  1  out_idx valid
- out_ready  input  1  consumer accepts the beat
- out_last  output  1  final beat of the current vector
- out_zero  output  1  accepted vector was all-zero

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, takes effect immediately, no clock needed):
  - state=IDLE, pend=0.
  - in_ready=0, out_valid=0, out_idx=0, out_last=0, out_zero=0.
- First rising edge with rst_n high: in_ready goes to 1.
- States, encoded as an enum from the package:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid&&in_ready: pend<=in_vec, in_ready<=0, go to EMIT.
    - If in_vec==0, additionally zero_r<=1.
  - EMIT: out_valid=1 and in_ready=0.
    - out_idx = priority index of pend (per LSB_FIRST).
    - out_last = exactly one bit set in pend, or zero_r.
    - out_zero = zero_r.
- Beat accept: out_valid&&out_ready.
  - Clear the emitted bit in pend.
  - If out_last: go to IDLE and clear zero_r; in_ready returns to 1 on that same edge.
- All-zero vector: exactly one beat with out_idx=0, out_zero=1, out_last=1.
- Latency: input accepted at edge T produces the first out_valid after edge T; beats are then back-to-back while out_ready=1.
- A vector with k set bits occupies k beats; the next vector can be accepted on the edge after the last beat.
- Backpressure: while out_valid&&!out_ready, out_idx, out_last and out_zero hold stable.
- in_valid/in_vec are ignored in EMIT; the upstream must hold them until in_ready.
- No combinational path from in_* or out_ready to any output. All outputs derive from state, pend and zero_r registers only.
- Reset mid-EMIT: pending bits are discarded and no residual beats appear after release.

Optional Feature:
- Macro: ENC_COUNT_EN.
- Defined: adds output port out_cnt, width IDX_W+1.
  - out_cnt = popcount(pend), the number of beats remaining including the current one.
  - out_cnt = 1 for the zero-vector beat.
  - out_cnt is 0 in IDLE and during reset.
- Undefined: the port and popcount logic are absent. All other behaviour is identical.

Decomposition:
- Package enc_pkg contains:
  - state typedef enum {IDLE, EMIT};
  - default N_IN constant;
  - idx_w function.
- One natural sub-module: prio_find, a combinational N_IN-to-IDX_W priority finder.
  - Parameterised by LSB_FIRST.
  - Outputs the index plus a one-hot clear mask.
  - Instantiated once on pend.

Test Plan:
- in_vec=8'b0000_0001, out_ready=1 -> one beat: idx=0, last=1, zero=0; in_ready=1 the cycle after.
- in_vec=8'b1010_0101, LSB_FIRST=0, out_ready=1 -> idx 7,5,2,0 on 4 consecutive cycles; last only on idx 0.
- in_vec=8'h00 -> single beat: idx=0, zero=1, last=1; then back to IDLE.
- in_vec=8'hFF with out_ready toggling 1,0,1,0 and in_valid held high with a new value -> idx 7..0 in order, held while stalled, new vector accepted only after idx 0 beat.
- in_vec=8'hF0, rst_n pulsed low after 2 beats (7,6) -> out_valid falls immediately; after release in_ready=1, no idx 5/4 beats ever appear.
- LSB_FIRST=1, in_vec=8'b1010_0101 -> idx 0,2,5,7.
- With ENC_COUNT_EN, in_vec=8'b1010_0101 -> out_cnt 4,3,2,1 alongside the beats.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and helpers for the enc8x3 serializer.
// Optional popcount output is enabled with ENC_COUNT_EN.
package enc_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  localparam int N_IN_DEF = 8;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational priority finder: index of the winning set bit
// plus a one-hot mask that clears it.
module prio_find
  import enc_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter bit LSB_FIRST = 1'b0,
  localparam int IDX_W    = idx_w(N_IN)
) (
  input  logic [N_IN-1:0]  vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [N_IN-1:0]  clr_o
);

  // Scan so that the preferred end is visited last and wins.
  always_comb begin
    idx_o = '0;
    clr_o = '0;
    if (LSB_FIRST) begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (vec_i[i]) begin
          idx_o = IDX_W'(i);
          clr_o = N_IN'(1) << i;
        end
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (vec_i[i]) begin
          idx_o = IDX_W'(i);
          clr_o = N_IN'(1) << i;
        end
      end
    end
  end

endmodule

// File: rtl/enc8x3_serializer.sv
// Sequential 8-to-3 encoder: latches a request vector and emits one
// index per beat. Define ENC_COUNT_EN to add the out_cnt port.
module enc8x3_serializer
  import enc_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter bit LSB_FIRST = 1'b0,
  localparam int IDX_W    = idx_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_zero
`ifdef ENC_COUNT_EN
  ,
  output logic [IDX_W:0]   out_cnt
`endif
);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   pend_q, pend_d;
  logic [N_IN-1:0]   clr;
  logic              zero_q, zero_d;
  logic              rdy_q, rdy_d;
  logic [IDX_W-1:0]  idx;
  logic              beat;

  prio_find #(
    .N_IN      (N_IN),
    .LSB_FIRST (LSB_FIRST)
  ) u_prio (
    .vec_i (pend_q),
    .idx_o (idx),
    .clr_o (clr)
  );

  assign out_valid = (state_q == EMIT);
  assign out_idx   = idx;
  assign out_last  = out_valid && ($onehot(pend_q) || zero_q);
  assign out_zero  = zero_q;
  assign in_ready  = rdy_q;
  assign beat      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = zero_q;
    rdy_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (in_valid && rdy_q) begin
          state_d = EMIT;
          pend_d  = in_vec;
          zero_d  = (in_vec == '0);
          rdy_d   = 1'b0;
        end
      end
      EMIT: begin
        if (beat) begin
          pend_d = pend_q & ~clr;
          if (out_last) begin
            state_d = IDLE;
            zero_d  = 1'b0;
            rdy_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef ENC_COUNT_EN
  // The zero-vector beat still counts as one remaining beat.
  always_comb begin
    out_cnt = '0;
    if (out_valid) begin
      out_cnt = zero_q ? (IDX_W + 1)'(1)
                       : (IDX_W + 1)'($countones(pend_q));
    end
  end
`endif

endmodule
